// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op and state enums plus small decode helpers.
package mdu_unit_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == MDU_DIVU) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign fix-up.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HIWr,
    input  logic             LOWr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    mdu_op_e            op_in;
    logic               in_signed;
    logic               in_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Magnitudes: the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        op_in     = mdu_op_e'(op);
        in_signed = op_is_signed(op_in);
        in_div    = op_is_div(op_in);
        mag_a     = (in_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        mag_b     = (in_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    // Multiply keeps the multiplier in the low half and shifts right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide keeps remainder high, dividend/quotient low, shifting left.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
        if (bzero_q) begin
            quot_fix = {WIDTH{1'b1}};
        end else if (neg_a_q ^ neg_b_q) begin
            quot_fix = ~acc_q[WIDTH-1:0] + 1'b1;
        end else begin
            quot_fix = acc_q[WIDTH-1:0];
        end
        rem_fix = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                          : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        bzero_d = bzero_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    neg_a_d = in_signed & A[WIDTH-1];
                    neg_b_d = in_signed & B[WIDTH-1];
                    bzero_d = in_div & (B == '0);
                    opnd_d  = in_div ? mag_b : mag_a;
                    acc_d   = {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
                    cnt_d   = '0;
                    state_d = MDU_CALC;
                end else begin
                    if (HIWr) hi_d = A;
                    if (LOWr) lo_d = A;
                end
            end
            MDU_CALC: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            op_q    <= MDU_MULTU;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            bzero_q <= bzero_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != MDU_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath.
- Sits directly downstream of the register file. It consumes the two register read operands (rs in A, rt in B) and implements MULT, MULTU, DIV and DIVU into private HI/LO registers.
- HI/LO are read back by the writeback mux for MFHI/MFLO. They are written directly by MTHI/MTLO.
- The control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin the operation selected by op. Sampled only in IDLE.
- op  input  2  operation select; encodings under Decomposition.
- A  input  WIDTH  operand rs: dividend or multiplicand.
- B  input  WIDTH  operand rt: divisor or multiplier.
- HIWr  input  1  MTHI: HI <= A.
- LOWr  input  1  MTLO: LO <= A.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when the HI/LO result becomes valid.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - HI=0, LO=0, busy=0, done=0.
  - Any in-flight operation is abandoned.
  - rst has priority over every other input.
- States: IDLE, CALC, FIX.
- IDLE:
  - If start=1, latch op, A and B. Latch operand magnitudes: for signed ops take the absolute value; 0x80000000 maps to magnitude 2^31 unsigned. Record the sign flags. Set counter=0 and go to CALC.
  - If start=1, HIWr and LOWr are ignored that cycle.
  - Otherwise HIWr/LOWr update HI/LO at the edge. Both may be set in the same cycle.
- CALC: one step per cycle, WIDTH cycles total.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After the step with counter=WIDTH-1, go to FIX.
- FIX: one cycle.
  - Apply sign correction. Product is negated (2*WIDTH bits) if the sign flags differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Write the result: multiply gives HI=upper, LO=lower. Divide gives LO=quotient, HI=remainder.
  - Go to IDLE with done=1 for exactly the following cycle.
- Timing:
  - busy=1 in CALC and FIX, which is WIDTH+1 = 33 cycles.
  - With start sampled at edge 0, busy is high cycles 1..33. HI/LO are new and done=1 in cycle 34.
  - HI/LO hold their old values until the FIX edge, never intermediate values.
- start while busy: ignored; no queueing.
- HIWr/LOWr while busy: ignored.
- start in the done cycle: accepted, because the state is IDLE.
- Divide by zero (B=0, signed or unsigned): LO=all ones, HI=A as latched. Same 33-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Operands A/B may change after the start cycle without effect.

Decomposition:
- The global definitions include file carries `MDU_MULTU=2'b00, `MDU_MULT=2'b01, `MDU_DIVU=2'b10, `MDU_DIV=2'b11.
- It also carries the state encodings `MDU_IDLE, `MDU_CALC, `MDU_FIX.
- Single module; no sub-module required. Sign fix-up and the step datapath are inline.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy high for 33 cycles; done in cycle 34; HI=0xFFFFFFFE LO=0x00000001.
- MULT A=0xFFFFFFFD(-3) B=5 -> HI=0xFFFFFFFF LO=0xFFFFFFF1. MULT A=0x80000000 B=0x80000000 -> HI=0x40000000 LO=0.
- DIVU A=100 B=7 -> LO=0x0000000E HI=0x00000002. DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0.
- DIV A=0x12345678 B=0 -> LO=0xFFFFFFFF HI=0x12345678 after 33 busy cycles.
- IDLE with HIWr=1 A=0xDEADBEEF -> HI=0xDEADBEEF next cycle. During busy, HIWr=1 and start=1 are both ignored, and HI/LO are unchanged until done. start+LOWr in the same IDLE cycle -> the operation starts and LO is not written.
- rst=1 at busy cycle 10 -> next cycle busy=0 done=0 HI=LO=0. A new MULTU 3*4 started afterwards -> LO=12 HI=0.
